// File: rtl/data_mem_resp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_resp_pkg
//  Description : Shared types and constants for the data-memory responder:
//                access-size encodings, FSM state enum, wait-counter width,
//                and the alignment helper used at request acceptance.
//  Revision    : 1.0  initial release
// ============================================================================
package data_mem_resp_pkg;

    // Width of the wait-state counter; covers WAIT_CYCLES 0..15.
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        RD   = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_e;

    // True when the byte offset is not legal for the access size.
    // The reserved size is always rejected.
    function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
        logic r;
        r = 1'b1;
        case (sz)
            SZ_WORD: r = (off != 2'b00);
            SZ_HALF: r = off[0];
            SZ_BYTE: r = 1'b0;
            SZ_RSVD: r = 1'b1;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_unit
//  Description : Combinational little-endian lane logic. Extracts a
//                right-justified, zero-extended load value from a memory word
//                and builds the merged word for a (sub-word) store.
//  Ports       : word       in  32  memory word being accessed
//                byte_off   in   2  byte offset within the word (addr[1:0])
//                size       in   2  access size (size_e)
//                wdata      in  32  right-justified store data
//                load_data  out 32  extracted load result
//                store_word out 32  word with the addressed lane replaced
//  Revision    : 1.0  initial release
// ============================================================================
module mem_lane_unit
    import data_mem_resp_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  size_e       size,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    always_comb begin
        load_data  = '0;
        store_word = word;
        case (size)
            SZ_WORD: begin
                load_data  = word;
                store_word = wdata;
            end
            SZ_HALF: begin
                load_data  = {16'b0, word[{byte_off[1], 4'b0000} +: 16]};
                store_word[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
            end
            SZ_BYTE: begin
                load_data  = {24'b0, word[{byte_off, 3'b000} +: 8]};
                store_word[{byte_off, 3'b000} +: 8] = wdata[7:0];
            end
            default: begin
                load_data  = '0;
                store_word = word;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Slow memory model for the multicycle CPU load/store path.
//                Accepts one request at a time, inserts WAIT_CYCLES wait
//                states, serves word/half/byte accesses from a word array,
//                performs sub-word stores as read-modify-write and returns an
//                error response for malformed requests.
//  Ports       : clk    in   1  clock
//                reset  in   1  asynchronous active-high reset
//                req    in   1  request strobe (sampled in IDLE only)
//                we     in   1  1 = store, 0 = load
//                size   in   2  00 word, 01 half, 10 byte, 11 reserved
//                addr   in  32  byte address
//                wdata  in  32  right-justified store data
//                busy   out  1  high while not IDLE
//                ready  out  1  one-cycle response pulse
//                rdata  out 32  load result, held until next response
//                err    out  1  error flag, held with rdata
//  Revision    : 1.0  initial release
// ============================================================================
module data_mem_responder
    import data_mem_resp_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int c_DEPTH = 1 << ADDR_W;
    // The counter is loaded with WAIT_CYCLES-1 and WAIT exits when it hits 0.
    localparam logic [WAIT_CNT_W-1:0] c_WAIT_LOAD =
        WAIT_CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [WAIT_CNT_W-1:0]  r_wait_cnt;
    logic [ADDR_W+1:0]      r_addr;
    logic                   r_we;
    size_e                  r_size;
    logic [31:0]            r_wdata;
    logic [31:0]            r_word;
    logic [31:0]            r_mem [c_DEPTH];

    logic                   w_accept;
    logic                   w_bad_req;
    logic [31:0]            w_mem_rd;
    logic [31:0]            w_lane_word;
    logic [31:0]            w_load_data;
    logic [31:0]            w_store_word;

    // Request legality is judged on the live inputs at the accept edge so
    // that a bad request can go straight to RESP.
    assign w_bad_req = is_misaligned(size_e'(size), addr[1:0])
                    || ((addr >> (ADDR_W + 2)) != 32'd0);

    assign w_mem_rd    = r_mem[r_addr[ADDR_W+1:2]];
    // RD extracts from the array output; WR merges into the word captured in RD.
    assign w_lane_word = (r_state == WR) ? r_word : w_mem_rd;

    mem_lane_unit u_lane (
        .word       (w_lane_word),
        .byte_off   (r_addr[1:0]),
        .size       (r_size),
        .wdata      (r_wdata),
        .load_data  (w_load_data),
        .store_word (w_store_word)
    );

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_accept = 1'b1;
                    if (w_bad_req) begin
                        w_state_nxt = RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        w_state_nxt = RD;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_state_nxt = RD;
                end
            end
            RD:      w_state_nxt = r_we ? WR : RESP;
            WR:      w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Request latches, wait counter and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_size     <= SZ_WORD;
            r_wdata    <= '0;
            busy       <= 1'b0;
            ready      <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
        end else begin
            // Outputs are registered from the next state so they line up
            // with the state they describe.
            busy  <= (w_state_nxt != IDLE);
            ready <= (w_state_nxt == RESP);

            if (w_accept) begin
                r_addr     <= addr[ADDR_W+1:0];
                r_we       <= we;
                r_size     <= size_e'(size);
                r_wdata    <= wdata;
                r_wait_cnt <= c_WAIT_LOAD;
            end else if ((r_state == WAIT) && (r_wait_cnt != '0)) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end

            if (w_accept && w_bad_req) begin
                err   <= 1'b1;
                rdata <= '0;
            end else if ((r_state == RD) && !r_we) begin
                err   <= 1'b0;
                rdata <= w_load_data;
            end else if (r_state == WR) begin
                err   <= 1'b0;
                rdata <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Word array. Not reset; an asynchronous reset moves the FSM out of WR
    // before the edge, which is what aborts an in-flight store.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (r_state == RD) begin
            r_word <= w_mem_rd;
        end
        if (r_state == WR) begin
            r_mem[r_addr[ADDR_W+1:2]] <= w_store_word;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Self-checking bench for data_mem_responder. Instance A uses
//                WAIT_CYCLES=1, instance B uses WAIT_CYCLES=0. Directed
//                vectors, multi-cycle corner sequences and a randomized run
//                against a byte-addressed reference memory.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_a, we_a, req_b, we_b;
    logic [1:0]  size_a, size_b;
    logic [31:0] addr_a, wdata_a, addr_b, wdata_b;
    logic        busy_a, ready_a, err_a, busy_b, ready_b, err_b;
    logic [31:0] rdata_a, rdata_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] mb [1024];   // reference memory for instance A, byte view

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .req(req_a), .we(we_a), .size(size_a),
        .addr(addr_a), .wdata(wdata_a), .busy(busy_a), .ready(ready_a),
        .rdata(rdata_a), .err(err_a)
    );

    data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req_b), .we(we_b), .size(size_b),
        .addr(addr_b), .wdata(wdata_b), .busy(busy_b), .ready(ready_b),
        .rdata(rdata_b), .err(err_b)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic w, logic [1:0] sz, logic [31:0] a,
                                logic [31:0] wd, logic [31:0] er, logic ee, int el);
        vec_t v;
        v.we = w; v.size = sz; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic busy_of(bit s);  return s ? busy_b  : busy_a;  endfunction
    function automatic logic ready_of(bit s); return s ? ready_b : ready_a; endfunction
    function automatic logic err_of(bit s);   return s ? err_b   : err_a;   endfunction
    function automatic logic [31:0] rdata_of(bit s); return s ? rdata_b : rdata_a; endfunction

    task automatic drive(bit s, logic r, logic w, logic [1:0] sz, logic [31:0] a, logic [31:0] wd);
        if (s) begin req_b = r; we_b = w; size_b = sz; addr_b = a; wdata_b = wd; end
        else   begin req_a = r; we_a = w; size_a = sz; addr_a = a; wdata_a = wd; end
    endtask

    // One complete transaction; returns response and latency in edges after
    // the accept edge. Also checks that ready drops in the following cycle.
    task automatic txn(input bit s, input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic e, output int lat);
        int  n;
        bit  got;
        @(negedge clk);
        n = 0;
        while (busy_of(s) && n < 50) begin
            @(negedge clk);
            n++;
        end
        drive(s, 1'b1, w, sz, a, wd);
        @(posedge clk);
        #1;
        drive(s, 1'b0, w, sz, a, wd);
        got = 1'b0;
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            if (ready_of(s)) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        rd = rdata_of(s);
        e  = err_of(s);
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout actual=no_ready required=ready addr=%h", a);
            lat = -1;
        end
        @(posedge clk);
        #1;
        chk("ready_single_pulse", {31'b0, ready_of(s)}, 32'd0);
    endtask

    task automatic model_txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, output logic [31:0] rd,
                             output logic e, output int lat);
        int nb;
        nb = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
        e  = (sz == 2'd3) || (a >= 32'd1024) || ((a % nb) != 0);
        rd = 32'd0;
        if (e) begin
            lat = 0;
        end else if (w) begin
            for (int i = 0; i < nb; i++) mb[a + i] = 8'((wd >> (8 * i)) & 32'hFF);
            lat = 3;
        end else begin
            for (int i = 0; i < nb; i++) rd = rd | (32'(mb[a + i]) << (8 * i));
            lat = 2;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, erd, a, wd;
        logic        e, ee, w;
        logic [1:0]  sz;
        int          lat, elat, pick, r;

        reset = 1'b1;
        drive(0, 0, 0, 2'd0, 32'd0, 32'd0);
        drive(1, 0, 0, 2'd0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy",  {31'b0, busy_a},  32'd0);
        chk("reset_ready", {31'b0, ready_a}, 32'd0);
        chk("reset_err",   {31'b0, err_a},   32'd0);
        chk("reset_rdata", rdata_a,          32'd0);
        chk("reset_busy_b", {31'b0, busy_b}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- directed vectors, WAIT_CYCLES=1 ----------------
        tbl.push_back(mk(1, 2'd0, 32'h10,  32'hDEADBEEF, 32'h0,        0, 3));
        tbl.push_back(mk(0, 2'd0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 2));
        tbl.push_back(mk(1, 2'd2, 32'h11,  32'h000000AA, 32'h0,        0, 3));
        tbl.push_back(mk(0, 2'd0, 32'h10,  32'h0,        32'hDEADAAEF, 0, 2));
        tbl.push_back(mk(0, 2'd2, 32'h13,  32'h0,        32'h000000DE, 0, 2));
        tbl.push_back(mk(1, 2'd1, 32'h12,  32'h00001234, 32'h0,        0, 3));
        tbl.push_back(mk(0, 2'd0, 32'h10,  32'h0,        32'h1234AAEF, 0, 2));
        tbl.push_back(mk(0, 2'd1, 32'h12,  32'h0,        32'h00001234, 0, 2));
        tbl.push_back(mk(0, 2'd0, 32'h12,  32'h0,        32'h0,        1, 0));
        tbl.push_back(mk(0, 2'd1, 32'h13,  32'h0,        32'h0,        1, 0));
        tbl.push_back(mk(0, 2'd3, 32'h10,  32'h0,        32'h0,        1, 0));
        tbl.push_back(mk(0, 2'd0, 32'h400, 32'h0,        32'h0,        1, 0));
        tbl.push_back(mk(1, 2'd1, 32'h11,  32'hFFFFFFFF, 32'h0,        1, 0));
        tbl.push_back(mk(0, 2'd0, 32'h10,  32'h0,        32'h1234AAEF, 0, 2));
        tbl.push_back(mk(1, 2'd0, 32'h0,   32'hCAFEF00D, 32'h0,        0, 3));
        tbl.push_back(mk(1, 2'd2, 32'h400, 32'h00000077, 32'h0,        1, 0));
        tbl.push_back(mk(0, 2'd0, 32'h0,   32'h0,        32'hCAFEF00D, 0, 2));
        tbl.push_back(mk(1, 2'd2, 32'h3FF, 32'h0000005A, 32'h0,        0, 3));
        tbl.push_back(mk(0, 2'd2, 32'h3FF, 32'h0,        32'h0000005A, 0, 2));
        tbl.push_back(mk(1, 2'd0, 32'h20,  32'h11111111, 32'h0,        0, 3));
        tbl.push_back(mk(0, 2'd0, 32'h20,  32'h0,        32'h11111111, 0, 2));

        foreach (tbl[i]) begin
            txn(0, tbl[i].we, tbl[i].size, tbl[i].addr, tbl[i].wdata, rd, e, lat);
            chk($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("vec%0d err", i), {31'b0, e}, {31'b0, tbl[i].exp_err});
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].exp_lat));
        end

        // ---------------- held req: accepted only on IDLE cycles ---------
        // Period is accept, WAIT, RD, RESP, IDLE -> accept every 4 edges.
        @(negedge clk);
        drive(0, 1, 0, 2'd0, 32'h10, 32'h0);
        for (int k = 0; k < 13; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("held_busy_e%0d", k),  {31'b0, busy_a},  {31'b0, (k % 4) != 3});
            chk($sformatf("held_ready_e%0d", k), {31'b0, ready_a}, {31'b0, (k % 4) == 2});
            if ((k % 4) == 2) chk($sformatf("held_rdata_e%0d", k), rdata_a, 32'h1234AAEF);
        end
        drive(0, 0, 0, 2'd0, 32'h10, 32'h0);

        // ---------------- reset during WAIT of a store -------------------
        txn(0, 0, 2'd0, 32'h20, 32'h0, rd, e, lat);
        chk("pre_reset_load", rd, 32'h11111111);
        @(negedge clk);
        drive(0, 1, 1, 2'd0, 32'h20, 32'h55555555);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 2'd0, 32'h0, 32'h0);
        chk("store_busy_wait", {31'b0, busy_a}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_busy",  {31'b0, busy_a},  32'd0);
        chk("rst_mid_ready", {31'b0, ready_a}, 32'd0);
        chk("rst_mid_err",   {31'b0, err_a},   32'd0);
        chk("rst_mid_rdata", rdata_a,          32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        txn(0, 0, 2'd0, 32'h20, 32'h0, rd, e, lat);
        chk("aborted_store_word", rd, 32'h11111111);

        // ---------------- reset during RESP drops ready at once ----------
        @(negedge clk);
        drive(0, 1, 0, 2'd0, 32'h10, 32'h0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 2'd0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("resp_ready_before_reset", {31'b0, ready_a}, 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("resp_ready_after_reset", {31'b0, ready_a}, 32'd0);
        chk("resp_busy_after_reset",  {31'b0, busy_a},  32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- zero wait states (instance B) -------------------
        txn(1, 1, 2'd0, 32'h10, 32'h0BADCAFE, rd, e, lat);
        chk("w0_store_lat", 32'(lat), 32'd2);
        chk("w0_store_err", {31'b0, e}, 32'd0);
        txn(1, 0, 2'd0, 32'h10, 32'h0, rd, e, lat);
        chk("w0_load_lat", 32'(lat), 32'd1);
        chk("w0_load_rdata", rd, 32'h0BADCAFE);
        txn(1, 0, 2'd2, 32'h11, 32'h0, rd, e, lat);
        chk("w0_byte_rdata", rd, 32'h000000CA);
        txn(1, 0, 2'd0, 32'h2, 32'h0, rd, e, lat);
        chk("w0_err_lat", 32'(lat), 32'd0);
        chk("w0_err_flag", {31'b0, e}, 32'd1);

        // ---------------- randomized run vs byte-level model -------------
        for (int i = 0; i < 256; i++) begin
            wd = $urandom;
            model_txn(1, 2'd0, 32'(i * 4), wd, erd, ee, elat);
            txn(0, 1, 2'd0, 32'(i * 4), wd, rd, e, lat);
            chk($sformatf("init%0d err", i), {31'b0, e}, {31'b0, ee});
        end
        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            pick = $urandom_range(0, 9);
            if (pick == 0)      a = 32'd1024 + $urandom_range(0, 4095);
            else if (pick == 1) a = $urandom | 32'h8000_0000;
            else begin
                a = $urandom_range(0, 1023);
                if (pick >= 4) begin
                    if (sz == 2'd1) a = a & ~32'd1;
                    else if (sz != 2'd2) a = a & ~32'd3;
                end
            end
            w  = 1'($urandom_range(0, 1));
            wd = $urandom;
            model_txn(w, sz, a, wd, erd, ee, elat);
            txn(0, w, sz, a, wd, rd, e, lat);
            chk($sformatf("rnd%0d rdata a=%h sz=%0d we=%0d", i, a, sz, w), rd, erd);
            chk($sformatf("rnd%0d err", i), {31'b0, e}, {31'b0, ee});
            chk($sformatf("rnd%0d latency", i), 32'(lat), 32'(elat));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
